// File: rtl/ram_responder_if.sv
// ---------------------------------------------------------------------------
// ram_responder_if
//   RAM bus between memory_control (master) and the RAM model (slave).
//   Signals:
//     Ren      master->slave  read request, held until completion
//     Wen      master->slave  write request, held until completion
//     ramaddr  master->slave  32-bit byte address
//     ramstore master->slave  32-bit write data
//     ramload  slave->master  32-bit read data, valid in the completion cycle
//     busy_o   slave->master  0 in the completion cycle, 1 otherwise
//     err_o    slave->master  access error flag (only when RAM_ERR_EN is defined)
//   Optional feature macro: RAM_ERR_EN
// ---------------------------------------------------------------------------
interface ram_responder_if;
    logic        Ren;
    logic        Wen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        busy_o;
`ifdef RAM_ERR_EN
    logic        err_o;
`endif

`ifdef RAM_ERR_EN
    modport master (output Ren, output Wen, output ramaddr, output ramstore,
                    input ramload, input busy_o, input err_o);
    modport slave  (input Ren, input Wen, input ramaddr, input ramstore,
                    output ramload, output busy_o, output err_o);
`else
    modport master (output Ren, output Wen, output ramaddr, output ramstore,
                    input ramload, input busy_o);
    modport slave  (input Ren, input Wen, input ramaddr, input ramstore,
                    output ramload, output busy_o);
`endif
endinterface

// File: rtl/ram_responder.sv
// ---------------------------------------------------------------------------
// ram_responder
//   Main-memory model at the target end of the RAM bus. Accepts single-word
//   read/write requests, waits LAT cycles, then completes by dropping busy_o
//   for exactly one cycle (DONE). Read data is registered on entry to DONE;
//   writes commit on the edge that leaves DONE.
//
//   Parameters:
//     ADDR_W  word-address width, depth = 2**ADDR_W 32-bit words (<= 29)
//     LAT     wait cycles between accept and completion (0..255)
//   Ports:
//     CLK     clock, rising edge
//     nRST    asynchronous active-low reset
//     bus     ram_responder_if.slave (Ren, Wen, ramaddr, ramstore,
//             ramload, busy_o, err_o when enabled)
//   Optional feature macro: RAM_ERR_EN
//     When defined, err_o is high in DONE if the accepted request had a
//     misaligned address, address bits above the array, or Ren&Wen together.
// ---------------------------------------------------------------------------
module ram_responder #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input  logic            CLK,
    input  logic            nRST,
    ram_responder_if.slave  bus
);

    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [7:0] LAT_C = 8'(LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Storage: not reset, written only from the DONE state.
    logic [31:0] mem [0:DEPTH-1];

    state_t              state_q,   state_d;
    logic [7:0]          counter_q, counter_d;
    logic                we_q,      we_d;
    logic [ADDR_W-1:0]   idx_q,     idx_d;
    logic [31:0]         data_q,    data_d;
    logic [31:0]         ramload_q;
    logic                busy_q;

    logic [ADDR_W-1:0]   addr_idx;
    logic                rd_fire;

    // Word index: byte offset dropped, upper bits ignored (wrap modulo depth).
    assign addr_idx = bus.ramaddr[ADDR_W+1:2];

`ifdef RAM_ERR_EN
    logic        err_lat_q, err_lat_d;
    logic        err_q;
    logic        err_now;
    logic [31:0] addr_hi;

    assign addr_hi = bus.ramaddr >> (ADDR_W + 2);
    assign err_now = (bus.ramaddr[1:0] != 2'b00) || (addr_hi != 32'd0) ||
                     (bus.Ren && bus.Wen);
`else
    // Byte offset and upper address bits carry no meaning without error checks.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.ramaddr[1:0], bus.ramaddr[31:ADDR_W+2]};
`endif

    // ------------------------------------------------------------------
    // Next-state / request latching
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        we_d      = we_q;
        idx_d     = idx_q;
        data_d    = data_q;
`ifdef RAM_ERR_EN
        err_lat_d = err_lat_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.Ren || bus.Wen) begin
                    we_d      = bus.Wen;        // write wins when both are high
                    idx_d     = addr_idx;
                    data_d    = bus.ramstore;
                    counter_d = LAT_C;
`ifdef RAM_ERR_EN
                    err_lat_d = err_now;
`endif
                    state_d   = (LAT_C == 8'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!bus.Ren && !bus.Wen) begin
                    // Initiator withdrew the request: abandon it, nothing written.
                    counter_d = 8'd0;
                    state_d   = IDLE;
                end else begin
                    counter_d = counter_q - 8'd1;
                    if (counter_q == 8'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A read is captured on the edge that enters DONE. idx_d already holds
    // the live address when LAT=0 enters DONE straight from IDLE.
    assign rd_fire = (state_d == DONE) && !we_d;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            counter_q <= 8'd0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            data_q    <= 32'd0;
            ramload_q <= 32'd0;
            busy_q    <= 1'b1;
`ifdef RAM_ERR_EN
            err_lat_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            busy_q    <= (state_d != DONE);
            if (rd_fire) begin
                ramload_q <= mem[idx_d];
            end
`ifdef RAM_ERR_EN
            err_lat_q <= err_lat_d;
            err_q     <= (state_d == DONE) && err_lat_d;
`endif
        end
    end

    // Write commits as DONE is left, so a following accept already sees it.
    // A reset during the access returns state_q to IDLE and drops the write.
    always_ff @(posedge CLK) begin
        if (state_q == DONE && we_q) begin
            mem[idx_q] <= data_q;
        end
    end

    assign bus.ramload = ramload_q;
    assign bus.busy_o  = busy_q;
`ifdef RAM_ERR_EN
    assign bus.err_o   = err_q;
`endif

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

    logic CLK;
    logic nRST;

    int compared   = 0;
    int mismatched = 0;

    ram_responder_if b2 ();   // LAT=2 instance
    ram_responder_if b0 ();   // LAT=0 instance

    ram_responder #(.ADDR_W(10), .LAT(2)) dut2 (.CLK(CLK), .nRST(nRST), .bus(b2));
    ram_responder #(.ADDR_W(10), .LAT(0)) dut0 (.CLK(CLK), .nRST(nRST), .bus(b0));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel0, input logic re, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
        if (sel0) begin
            b0.Ren = re; b0.Wen = we; b0.ramaddr = addr; b0.ramstore = data;
        end else begin
            b2.Ren = re; b2.Wen = we; b2.ramaddr = addr; b2.ramstore = data;
        end
    endtask

    // One full access: request high from cycle 0, busy_o must be 1 in
    // cycles 0..LAT and 0 in cycle LAT+1. Called right after a posedge.
    task automatic access(input bit sel0, input logic re, input logic we,
                          input logic [31:0] addr, input logic [31:0] data,
                          input string tag, input bit chk_load,
                          input logic [31:0] exp_load, input bit exp_err);
        int lat;
        logic busy, err;
        logic [31:0] load;
        lat = sel0 ? 0 : 2;
        drive(sel0, re, we, addr, data);
        for (int c = 0; c <= lat + 1; c++) begin
            @(negedge CLK);
            busy = sel0 ? b0.busy_o : b2.busy_o;
            load = sel0 ? b0.ramload : b2.ramload;
            check($sformatf("%s_busy_c%0d", tag, c), {31'd0, busy}, {31'd0, (c != lat + 1)});
            if (c == lat + 1) begin
                if (chk_load) check({tag, "_load"}, load, exp_load);
`ifdef RAM_ERR_EN
                err = sel0 ? b0.err_o : b2.err_o;
                check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
`else
                err = exp_err;
`endif
            end
        end
        @(posedge CLK); #1;
        drive(sel0, 1'b0, 1'b0, 32'd0, 32'd0);
        $display("txn %s: re=%0b we=%0b addr=%h data=%h", tag, re, we, addr, data);
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", {31'd0, b2.busy_o}, 32'd1);
        check("rst_load", b2.ramload, 32'd0);
`ifdef RAM_ERR_EN
        check("rst_err", {31'd0, b2.err_o}, 32'd0);
`endif
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Basic write then read, LAT=2
        access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10", 1'b1, 32'h0, 1'b0);
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        "rd10", 1'b1, 32'hDEADBEEF, 1'b0);
        @(negedge CLK);
        check("load_held", b2.ramload, 32'hDEADBEEF);
        @(posedge CLK); #1;

        // Abort: prior value 0x1111, aborted write of 0x1234
        access(1'b0, 1'b0, 1'b1, 32'h20, 32'h1111, "wr20", 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h1234);
        @(posedge CLK); #1;                       // now in WAIT
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        check("abort_busy_c1", {31'd0, b2.busy_o}, 32'd1);
        @(negedge CLK);
        check("abort_busy_c2", {31'd0, b2.busy_o}, 32'd1);
        @(negedge CLK);
        check("abort_busy_c3", {31'd0, b2.busy_o}, 32'd1);
        $display("txn abort: wr20 dropped in WAIT");
        @(posedge CLK); #1;
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, "rd20", 1'b1, 32'h1111, 1'b0);

        // Address/data changes during WAIT are ignored
        drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h3030);
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h9999);
        repeat (3) @(posedge CLK); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        $display("txn wr30: addr/data changed during WAIT");
        access(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, "rd30", 1'b1, 32'h3030, 1'b0);
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, "rd20b", 1'b1, 32'h1111, 1'b0);

        // Wrap: 0x1004 aliases word 1
        access(1'b0, 1'b0, 1'b1, 32'h1004, 32'h55, "wr1004", 1'b0, 32'h0, 1'b1);
        access(1'b0, 1'b1, 1'b0, 32'h0004, 32'h0,  "rd0004", 1'b1, 32'h55, 1'b0);

        // Ren&Wen together is a write; misaligned read flags error
        access(1'b0, 1'b1, 1'b1, 32'h8, 32'hA5, "rdwr8", 1'b0, 32'h0, 1'b1);
        access(1'b0, 1'b1, 1'b0, 32'h8, 32'h0,  "rd8",   1'b1, 32'hA5, 1'b0);
        access(1'b0, 1'b1, 1'b0, 32'h9, 32'h0,  "rd9",   1'b1, 32'hA5, 1'b1);

        // Reset mid-WAIT drops the write and clears ramload
        access(1'b0, 1'b0, 1'b1, 32'h40, 32'h77, "wr40", 1'b0, 32'h0, 1'b0);
        access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0,  "rd40", 1'b1, 32'h77, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h99);
        @(posedge CLK); #1;                       // in WAIT
        nRST = 1'b0;
        @(negedge CLK);
        check("midrst_busy", {31'd0, b2.busy_o}, 32'd1);
        check("midrst_load", b2.ramload, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        $display("txn midrst: wr40 interrupted by reset");
        @(posedge CLK); #1;
        access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, "rd40b", 1'b1, 32'h77, 1'b0);

        // LAT=0 instance
        access(1'b1, 1'b0, 1'b1, 32'h0, 32'hCAFE, "z_wr0", 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        check("z_held_busy_c0", {31'd0, b0.busy_o}, 32'd1);
        @(negedge CLK);
        check("z_held_busy_c1", {31'd0, b0.busy_o}, 32'd0);
        check("z_held_load_c1", b0.ramload, 32'hCAFE);
        @(negedge CLK);
        check("z_held_busy_c2", {31'd0, b0.busy_o}, 32'd1);
        @(negedge CLK);
        check("z_held_busy_c3", {31'd0, b0.busy_o}, 32'd0);
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        $display("txn z_held: Ren held on LAT=0 instance");

        repeat (2) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
